// File: rtl/univ_shift_reg_n.sv
// WIDTH-bit universal shift register: hold/shift/load plus rotate, Johnson and LFSR modes,
// with a saturating shift counter and a cycle-complete detector. Option: JOHNSON_SELF_CORRECT_EN.
module univ_shift_reg_n #(
  parameter int unsigned          WIDTH = 4,
  parameter logic [WIDTH-1:0]     TAPS  = WIDTH'(4'b1100),
  parameter int unsigned          CNT_W = 8
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             cycle_done
);

  typedef enum logic [2:0] {
    M_HOLD    = 3'b000,
    M_SHR     = 3'b001,
    M_SHL     = 3'b010,
    M_LOAD    = 3'b011,
    M_ROTR    = 3'b100,
    M_ROTL    = 3'b101,
    M_JOHNSON = 3'b110,
    M_LFSR    = 3'b111
  } mode_e;

  mode_e            mode_s;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  assign mode_s = mode_e'(mode);

`ifdef JOHNSON_SELF_CORRECT_EN
  // Legal Johnson states have at most one boundary between adjacent differing bits.
  function automatic logic johnson_legal(input logic [WIDTH-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < WIDTH - 1; i++) begin
      if (v[i] != v[i+1]) n++;
    end
    return (n <= 1);
  endfunction
`endif

  always_comb begin
    q_d    = q_q;
    snap_d = snap_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    unique case (mode_s)
      M_HOLD:    q_d = q_q;
      M_SHR:     q_d = {sin_r, q_q[WIDTH-1:1]};
      M_SHL:     q_d = {q_q[WIDTH-2:0], sin_l};
      M_LOAD: begin
        q_d    = d;
        snap_d = d;
      end
      M_ROTR:    q_d = {q_q[0], q_q[WIDTH-1:1]};
      M_ROTL:    q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      M_JOHNSON: begin
`ifdef JOHNSON_SELF_CORRECT_EN
        if (johnson_legal(q_q)) q_d = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
        else                    q_d = '0;
`else
        q_d = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
`endif
      end
      M_LFSR: begin
        // All-zeros would lock the LFSR forever, so it is kicked to 1.
        if (q_q == '0) q_d = WIDTH'(1);
        else           q_d = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
      end
      default:   q_d = q_q;
    endcase

    if (mode_s == M_LOAD) begin
      cnt_d = '0;
    end else if (mode_s != M_HOLD && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    done_d = mode[2] && (q_d == snap_q);
  end

  always_ff @(posedge clk) begin
    if (!CLR) begin
      q_q    <= '0;
      snap_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      snap_q <= snap_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q          = q_q;
  assign sout_r     = q_q[0];
  assign sout_l     = q_q[WIDTH-1];
  assign shift_cnt  = cnt_q;
  assign cycle_done = done_q;

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Bench for univ_shift_reg_n: directed vector table, corner sequences, and randomized
// stimulus against an arithmetic reference model. Honours JOHNSON_SELF_CORRECT_EN.
module tb_univ_shift_reg_n;
  localparam logic [3:0] TP = 4'b1100;

  logic       clk = 1'b0;
  logic       CLR;
  logic [2:0] mode;
  logic [3:0] d;
  logic       sin_r, sin_l;
  logic [3:0] q, q4;
  logic       sout_r, sout_l, sout_r4, sout_l4;
  logic [7:0] cnt;
  logic [3:0] cnt4;
  logic       done, done4;

  int checks = 0;
  int errors = 0;

  int mq, msnap, mcnt, mcnt4;
  bit mdone;

  always #5 clk = ~clk;

  univ_shift_reg_n #(.WIDTH(4), .TAPS(4'b1100), .CNT_W(8)) dut (
    .clk(clk), .CLR(CLR), .mode(mode), .d(d), .sin_r(sin_r), .sin_l(sin_l),
    .q(q), .sout_r(sout_r), .sout_l(sout_l), .shift_cnt(cnt), .cycle_done(done)
  );

  univ_shift_reg_n #(.WIDTH(4), .TAPS(4'b1100), .CNT_W(4)) dut4 (
    .clk(clk), .CLR(CLR), .mode(mode), .d(d), .sin_r(sin_r), .sin_l(sin_l),
    .q(q4), .sout_r(sout_r4), .sout_l(sout_l4), .shift_cnt(cnt4), .cycle_done(done4)
  );

  typedef struct {
    bit       clr;
    int       m;
    int       dd;
    bit       sr;
    bit       sl;
    int       exp_q;
    int       exp_cnt;
    bit       exp_done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit c, int m, int dd, bit sr, bit sl, int eq, int ec, bit ed);
    vec_t v;
    v.clr = c; v.m = m; v.dd = dd; v.sr = sr; v.sl = sl;
    v.exp_q = eq; v.exp_cnt = ec; v.exp_done = ed;
    return v;
  endfunction

  // Reference next-state from the mode rules, using plain integer arithmetic on a 4-bit value.
  function automatic int nxt(int m, int cq, int dd, int sr, int sl);
    case (m)
      0: return cq;
      1: return (sr << 3) | (cq >> 1);
      2: return ((cq << 1) & 15) | sl;
      3: return dd & 15;
      4: return ((cq & 1) << 3) | (cq >> 1);
      5: return ((cq << 1) & 15) | (cq >> 3);
      6: begin
`ifdef JOHNSON_SELF_CORRECT_EN
        if ($countones((cq ^ (cq >> 1)) & 7) > 1) return 0;
`endif
        return ((cq << 1) & 15) | (1 - (cq >> 3));
      end
      default: begin
        if (cq == 0) return 1;
        return ((cq << 1) & 15) | ($countones(cq & int'(TP)) % 2);
      end
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit c, input int m, input int dd, input bit sr, input bit sl);
    int nq;
    CLR = c; mode = m[2:0]; d = dd[3:0]; sin_r = sr; sin_l = sl;
    @(posedge clk);
    if (!c) begin
      mq = 0; msnap = 0; mcnt = 0; mcnt4 = 0; mdone = 0;
    end else begin
      nq = nxt(m, mq, dd, sr, sl);
      mdone = (m >= 4) && (nq == msnap);
      if (m == 3) begin
        msnap = dd & 15; mcnt = 0; mcnt4 = 0;
      end else if (m != 0) begin
        if (mcnt < 255) mcnt++;
        if (mcnt4 < 15) mcnt4++;
      end
      mq = nq;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_q"}, int'(q), mq);
    chk({tag, "_sout_r"}, int'(sout_r), mq & 1);
    chk({tag, "_sout_l"}, int'(sout_l), (mq >> 3) & 1);
    chk({tag, "_cnt"}, int'(cnt), mcnt);
    chk({tag, "_cnt4"}, int'(cnt4), mcnt4);
    chk({tag, "_done"}, int'(done), int'(mdone));
  endtask

  initial begin
    int first_done;
    vec_t v;
    CLR = 1'b1; mode = 3'd0; d = 4'd0; sin_r = 1'b0; sin_l = 1'b0;
    mq = 0; msnap = 0; mcnt = 0; mcnt4 = 0; mdone = 0;

    tbl.push_back(mk(0, 0, 0,  0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 3, 10, 0, 0, 4'b1010, 0, 0));
    tbl.push_back(mk(0, 0, 0,  0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 3, 6,  0, 0, 4'b0110, 0, 0));
    tbl.push_back(mk(1, 2, 0,  0, 1, 4'b1101, 1, 0));
    tbl.push_back(mk(1, 2, 0,  0, 1, 4'b1011, 2, 0));
    tbl.push_back(mk(1, 3, 6,  0, 0, 4'b0110, 0, 0));
    tbl.push_back(mk(1, 1, 0,  0, 0, 4'b0011, 1, 0));
    tbl.push_back(mk(1, 1, 0,  0, 0, 4'b0001, 2, 0));
    tbl.push_back(mk(1, 3, 9,  0, 0, 4'b1001, 0, 0));
    tbl.push_back(mk(1, 5, 0,  0, 0, 4'b0011, 1, 0));
    tbl.push_back(mk(1, 5, 0,  0, 0, 4'b0110, 2, 0));
    tbl.push_back(mk(1, 5, 0,  0, 0, 4'b1100, 3, 0));
    tbl.push_back(mk(1, 5, 0,  0, 0, 4'b1001, 4, 1));
    tbl.push_back(mk(1, 0, 0,  0, 0, 4'b1001, 4, 0));
    tbl.push_back(mk(0, 0, 0,  0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 6, 0,  0, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 6, 0,  0, 0, 4'b0011, 2, 0));
    tbl.push_back(mk(1, 6, 0,  0, 0, 4'b0111, 3, 0));
    tbl.push_back(mk(1, 6, 0,  0, 0, 4'b1111, 4, 0));
    tbl.push_back(mk(1, 6, 0,  0, 0, 4'b1110, 5, 0));
    tbl.push_back(mk(1, 6, 0,  0, 0, 4'b1100, 6, 0));
    tbl.push_back(mk(1, 6, 0,  0, 0, 4'b1000, 7, 0));
    tbl.push_back(mk(1, 6, 0,  0, 0, 4'b0000, 8, 1));
    tbl.push_back(mk(1, 3, 0,  0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 7, 0,  0, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 3, 0,  0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 2, 0,  0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk(1, 1, 0,  0, 0, 4'b0000, 2, 0));
    tbl.push_back(mk(1, 3, 5,  0, 0, 4'b0101, 0, 0));
`ifdef JOHNSON_SELF_CORRECT_EN
    tbl.push_back(mk(1, 6, 0,  0, 0, 4'b0000, 1, 0));
`else
    tbl.push_back(mk(1, 6, 0,  0, 0, 4'b1011, 1, 0));
`endif

    foreach (tbl[i]) begin
      v = tbl[i];
      drive(v.clr, v.m, v.dd, v.sr, v.sl);
      chk($sformatf("vec%0d_q", i), int'(q), v.exp_q);
      chk($sformatf("vec%0d_cnt", i), int'(cnt), v.exp_cnt);
      chk($sformatf("vec%0d_done", i), int'(done), int'(v.exp_done));
      chk($sformatf("vec%0d_sout_r", i), int'(sout_r), v.exp_q & 1);
      chk($sformatf("vec%0d_sout_l", i), int'(sout_l), (v.exp_q >> 3) & 1);
    end

    // CLR low only between edges must not reset anything.
    drive(1, 3, 10, 0, 0);
    CLR = 1'b0;
    #3;
    CLR = 1'b1;
    drive(1, 0, 0, 0, 0);
    chk("clr_glitch_q", int'(q), 4'b1010);

    // LFSR period from 0001 is 15 with taps 1100.
    drive(1, 3, 1, 0, 0);
    first_done = 0;
    for (int i = 1; i <= 20 && first_done == 0; i++) begin
      drive(1, 7, 0, 0, 0);
      check_model($sformatf("lfsr%0d", i));
      if (done) first_done = i;
    end
    chk("lfsr_period", first_done, 15);

    // Counter saturation: 20 shifts on the 4-bit counter stops at 15.
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) drive(1, 1, 0, 1, 0);
    chk("sat_cnt4", int'(cnt4), 15);
    chk("sat_cnt8", int'(cnt), 20);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 15) != 0), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
      check_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
